// File: rtl/grf_write_arbiter.sv
// Single GRF write-port arbiter: the write-back stage always wins, while secondary
// producer results wait in a small in-order FIFO and drain only when the port is free.
module grf_write_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_we,
   input  logic [4:0]  w_addr,
   input  logic [31:0] w_data,
   input  logic [31:0] w_pc,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [4:0]  s_addr,
   input  logic [31:0] s_data,
   input  logic [31:0] s_pc,
   output logic        grf_we,
   output logic [4:0]  grf_a3,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_pc,
   input  logic [4:0]  q_addr,
   output logic        q_pending,
   output logic        stall_req
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    fifo_addr [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [31:0]   fifo_pc   [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [AW-1:0] age;

   logic prim_eff;
   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;

   // A primary write to $0 is a no-op and does not occupy the port.
   assign prim_eff   = !reset && w_we && (w_addr != 5'd0);
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(DEPTH));

   assign s_ready = !reset && !fifo_full;
   assign push    = s_valid && s_ready && (s_addr != 5'd0);
   assign pop     = !reset && !prim_eff && !fifo_empty;

   assign stall_req = !reset && (age >= AW'(STARVE_LIMIT));

   always_comb begin
      grf_we = 1'b0;
      grf_a3 = 5'd0;
      grf_wd = 32'd0;
      grf_pc = 32'd0;
      if (prim_eff) begin
         grf_we = 1'b1;
         grf_a3 = w_addr;
         grf_wd = w_data;
         grf_pc = w_pc;
      end else if (pop) begin
         grf_we = 1'b1;
         grf_a3 = fifo_addr[rd_ptr];
         grf_wd = fifo_data[rd_ptr];
         grf_pc = fifo_pc[rd_ptr];
      end
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      logic [PW-1:0] slot_off;
      logic          hit;
      slot_off = '0;
      hit      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_off = PW'(i) - rd_ptr;
         if (({1'b0, slot_off} < count) && (fifo_addr[i] == q_addr)) begin
            hit = 1'b1;
         end
      end
      q_pending = !reset && (q_addr != 5'd0) && hit;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= s_addr;
         fifo_data[wr_ptr] <= s_data;
         fifo_pc[wr_ptr]   <= s_pc;
      end
   end

   // Pointers wrap naturally; age only grows while a head sits unpopped.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         age    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (fifo_empty || pop) begin
            age <= '0;
         end else if (age < AW'(STARVE_LIMIT)) begin
            age <= age + AW'(1);
         end
      end
   end

endmodule

// File: doc/grf_write_arbiter.md
# grf_write_arbiter

Arbitrates the single write port of the general register file between the pipeline write-back stage (primary) and a multi-cycle secondary producer, such as a multiply/divide or coprocessor unit writing a GPR. Secondary results are buffered in a small FIFO and written only when the primary does not need the port. The block also raises a stall request when a secondary result has waited too long, and answers pending-write queries for hazard detection. It sits directly in front of the GRF write inputs (write enable, write address, write data, PC for trace).

## Interface
- DEPTH, 2: secondary FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4: cycles a FIFO head may wait before stall_req asserts (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- w_we  in  1  primary write request, always accepted
- w_addr  in  5  primary destination register
- w_data  in  32  primary write data
- w_pc  in  32  primary instruction PC
- s_valid  in  1  secondary result valid
- s_ready  out  1  FIFO can accept a secondary result
- s_addr  in  5  secondary destination register
- s_data  in  32  secondary write data
- s_pc  in  32  secondary instruction PC
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address
- grf_wd  out  32  GRF write data
- grf_pc  out  32  PC forwarded to GRF trace
- q_addr  in  5  hazard query register
- q_pending  out  1  a buffered secondary write targets q_addr
- stall_req  out  1  request upstream to free the port next cycle

## Operation
- Primary is effective when w_we=1 and w_addr≠0. A primary write to $0 is a no-op and leaves the port free.
- Port selection each cycle:
  - If primary is effective, grf_* = primary fields and grf_we=1.
  - Otherwise, if the FIFO is non-empty, grf_* = FIFO head fields, grf_we=1, and the head pops at the clock edge.
  - Otherwise grf_we=0, and grf_a3/grf_wd/grf_pc are 0.
- Secondary handshake:
  - A transfer occurs when s_valid && s_ready at a clock edge.
  - s_ready = !full, computed from registered count only. It does not depend on a same-cycle pop.
  - A transfer with s_addr=0 is accepted and discarded, never enqueued.
- FIFO is in-order, with circular read/write pointers of log2(DEPTH) bits that wrap naturally. A count of width log2(DEPTH)+1 tracks occupancy.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal whenever not full. When full, s_ready=0, so no push occurs.
- Primary and secondary targeting the same register need no merging. Writes reach the GRF in arbitration order, and the later write wins.
- Age counter:
  - Counts cycles the FIFO head is present but not popped. It saturates at STARVE_LIMIT.
  - It clears to 0 on pop and whenever the FIFO is empty.
- stall_req = (age ≥ STARVE_LIMIT).
  - Upstream is expected to drop w_we the next cycle.
  - If w_we stays effective, primary still wins. Data is never lost, and stall_req stays high.
- q_pending = (q_addr≠0) && some valid FIFO entry has addr == q_addr. It is combinational over the registered entries and does not include a same-cycle incoming s_* transfer.

## Timing
- Reset (synchronous): count, pointers and age go to 0. While reset=1:
  - grf_we=0, s_ready=0, stall_req=0, q_pending=0.
  - Primary inputs are ignored.
- grf_* are combinational from the current primary inputs and the registered FIFO head, giving zero-cycle latency for primary writes.
- Secondary latency: an entry pushed at edge N is eligible to write in cycle N+1 (after the edge) at the earliest.
- Reset asserted mid-operation flushes all buffered secondary writes. Those writes never reach the GRF.
- stall_req rises in the cycle after the age reaches STARVE_LIMIT. It falls in the cycle after the pop edge.

## Test plan
- Reset, then idle: grf_we=0, s_ready=1, stall_req=0, q_pending=0 for all addresses.
- Secondary only: push (addr=5, data=0x12345678, pc=0x3000) with no primary. The next cycle shows grf_we=1, grf_a3=5, grf_wd=0x12345678, grf_pc=0x3000. The cycle after shows grf_we=0.
- Contention:
  - Push addr=7, then hold w_we=1 with w_addr=3 for 5 cycles. grf_a3 stays 3.
  - With STARVE_LIMIT=4, stall_req=1 after 4 waiting cycles.
  - Drop w_we: grf_a3=7 that cycle, and stall_req=0 the next.
- Full/wrap:
  - With DEPTH=2 and primary busy, push 2 entries. s_ready=0, and a third s_valid is not accepted.
  - Free the port: entries drain in order.
  - Repeat 3 times to exercise pointer wrap; data order is preserved.
- $0 handling:
  - Secondary push with addr=0 is accepted and never written, with count unchanged.
  - Primary w_we=1, w_addr=0 with a buffered entry present: the buffered entry writes that cycle.
- Hazard/reset:
  - Buffer addr=9. q_addr=9 gives q_pending=1; q_addr=0 gives 0.
  - Assert reset one cycle: q_pending=0, FIFO empty, and no write of addr 9 ever occurs.
